// File: rtl/cache_fill_ctrl.sv
// Tag lookup, LRU replacement and page-fill sequencer for a 4-page cache on a 65816 phi2 bus.
// The CPU address is rebuilt from the bus, looked up, and on a miss a whole page is streamed in.
module cache_fill_ctrl #(
  parameter int unsigned PAGES     = 4,
  parameter int unsigned PAGE_BITS = 8,
  parameter int unsigned ADDR_W    = 24
) (
  input  logic                 fpga,
  input  logic                 reset,
  input  logic                 phi2,
  input  logic [15:0]          a,
  input  logic [7:0]           d,
  input  logic                 invalidate,
  input  logic [7:0]           mem_data,
  input  logic                 mem_ack,
  output logic                 hit,
  output logic [1:0]           hit_page,
  output logic                 rdy,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 fill_we,
  output logic [1:0]           fill_page,
  output logic [PAGE_BITS-1:0] fill_offset,
  output logic [7:0]           fill_data
);

  localparam int unsigned TAG_W  = ADDR_W - PAGE_BITS;
  localparam int unsigned BANK_W = ADDR_W - 16;

  typedef enum logic [2:0] {StIdle, StLookup, StReq, StWrite, StDone} state_e;

  logic                 phi2_s1_q, phi2_s2_q, phi2_s3_q;
  logic [15:0]          a_s1_q, a_s2_q;
  logic [7:0]           d_s1_q, d_s2_q;
  logic [BANK_W-1:0]    bank_lat_q, bank_lat_d;
  logic [15:0]          addr_lat_q, addr_lat_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  state_e               state_q, state_d;
  logic [PAGES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [PAGES];
  logic [TAG_W-1:0]     tag_d [PAGES];
  logic [1:0]           age_q [PAGES];
  logic [1:0]           age_d [PAGES];
  logic                 inv_pend_q, inv_pend_d;
  logic                 hit_q, hit_d;
  logic [1:0]           hit_page_q, hit_page_d;
  logic                 rdy_q, rdy_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 fill_we_q, fill_we_d;
  logic [1:0]           fill_page_q, fill_page_d;
  logic [PAGE_BITS-1:0] fill_offset_q, fill_offset_d;
  logic [7:0]           fill_data_q, fill_data_d;

  logic                 lookup_ev;
  logic [TAG_W-1:0]     cur_tag;
  logic                 hit_any;
  logic [1:0]           hit_idx;
  logic                 victim_found;
  logic [1:0]           victim;
  logic                 touch_en;
  logic [1:0]           touch_idx;

  // The byte offset of the CPU address plays no part in tag lookup.
  logic unused_offset_bits;
  assign unused_offset_bits = ^addr_q[PAGE_BITS-1:0];

  assign lookup_ev = ~phi2_s2_q & phi2_s3_q;
  assign cur_tag   = addr_q[ADDR_W-1:PAGE_BITS];

  always_comb begin
    hit_any = 1'b0;
    hit_idx = 2'd0;
    for (int i = 0; i < int'(PAGES); i++) begin
      if (valid_q[i] && (tag_q[i] == cur_tag)) begin
        hit_any = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  // Lowest invalid page wins; otherwise the single page with the oldest age.
  always_comb begin
    victim_found = 1'b0;
    victim       = 2'd0;
    for (int i = 0; i < int'(PAGES); i++) begin
      if (!valid_q[i] && !victim_found) begin
        victim_found = 1'b1;
        victim       = 2'(i);
      end
    end
    if (!victim_found) begin
      for (int i = 0; i < int'(PAGES); i++) begin
        if (age_q[i] == 2'd3) victim = 2'(i);
      end
    end
  end

  always_comb begin
    bank_lat_d    = phi2_s2_q ? bank_lat_q : d_s2_q[BANK_W-1:0];
    addr_lat_d    = phi2_s2_q ? a_s2_q : addr_lat_q;
    addr_d        = addr_q;
    state_d       = state_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    age_d         = age_q;
    inv_pend_d    = inv_pend_q;
    hit_d         = 1'b0;
    hit_page_d    = hit_page_q;
    rdy_d         = rdy_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    fill_we_d     = 1'b0;
    fill_page_d   = fill_page_q;
    fill_offset_d = fill_offset_q;
    fill_data_d   = fill_data_q;
    touch_en      = 1'b0;
    touch_idx     = 2'd0;

    // Lookup still resolves against valid_q, so a same-cycle invalidate cannot hide it.
    if (invalidate) begin
      if ((state_q == StIdle) || (state_q == StLookup)) valid_d = '0;
      else                                              inv_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (lookup_ev) begin
          addr_d  = {bank_lat_q, addr_lat_q};
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit_any) begin
          hit_d      = 1'b1;
          hit_page_d = hit_idx;
          touch_en   = 1'b1;
          touch_idx  = hit_idx;
          state_d    = StIdle;
        end else begin
          fill_page_d   = victim;
          fill_offset_d = '0;
          rdy_d         = 1'b0;
          mem_req_d     = 1'b1;
          mem_addr_d    = {cur_tag, {PAGE_BITS{1'b0}}};
          state_d       = StReq;
        end
      end
      StReq: begin
        if (mem_ack) begin
          fill_data_d = mem_data;
          fill_we_d   = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        if (&fill_offset_q) begin
          state_d = StDone;
        end else begin
          fill_offset_d = fill_offset_q + 1'b1;
          mem_req_d     = 1'b1;
          mem_addr_d    = {cur_tag, fill_offset_q + 1'b1};
          state_d       = StReq;
        end
      end
      StDone: begin
        tag_d[fill_page_q]   = cur_tag;
        valid_d[fill_page_q] = 1'b1;
        touch_en             = 1'b1;
        touch_idx            = fill_page_q;
        hit_page_d           = fill_page_q;
        rdy_d                = 1'b1;
        state_d              = StIdle;
        // A deferred invalidate lands on IDLE entry and takes the fresh page with it.
        if (inv_pend_d) begin
          valid_d    = '0;
          inv_pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (touch_en) begin
      for (int i = 0; i < int'(PAGES); i++) begin
        if (age_q[i] < age_q[touch_idx]) age_d[i] = age_q[i] + 2'd1;
      end
      age_d[touch_idx] = 2'd0;
    end
  end

  always_ff @(posedge fpga or posedge reset) begin
    if (reset) begin
      phi2_s1_q     <= 1'b0;
      phi2_s2_q     <= 1'b0;
      phi2_s3_q     <= 1'b0;
      a_s1_q        <= '0;
      a_s2_q        <= '0;
      d_s1_q        <= '0;
      d_s2_q        <= '0;
      bank_lat_q    <= '0;
      addr_lat_q    <= '0;
      addr_q        <= '0;
      state_q       <= StIdle;
      valid_q       <= '0;
      for (int i = 0; i < int'(PAGES); i++) begin
        tag_q[i] <= '0;
        age_q[i] <= 2'(i);
      end
      inv_pend_q    <= 1'b0;
      hit_q         <= 1'b0;
      hit_page_q    <= 2'd0;
      rdy_q         <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      fill_we_q     <= 1'b0;
      fill_page_q   <= 2'd0;
      fill_offset_q <= '0;
      fill_data_q   <= '0;
    end else begin
      phi2_s1_q     <= phi2;
      phi2_s2_q     <= phi2_s1_q;
      phi2_s3_q     <= phi2_s2_q;
      a_s1_q        <= a;
      a_s2_q        <= a_s1_q;
      d_s1_q        <= d;
      d_s2_q        <= d_s1_q;
      bank_lat_q    <= bank_lat_d;
      addr_lat_q    <= addr_lat_d;
      addr_q        <= addr_d;
      state_q       <= state_d;
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      age_q         <= age_d;
      inv_pend_q    <= inv_pend_d;
      hit_q         <= hit_d;
      hit_page_q    <= hit_page_d;
      rdy_q         <= rdy_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fill_we_q     <= fill_we_d;
      fill_page_q   <= fill_page_d;
      fill_offset_q <= fill_offset_d;
      fill_data_q   <= fill_data_d;
    end
  end

  assign hit         = hit_q;
  assign hit_page    = hit_page_q;
  assign rdy         = rdy_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign fill_we     = fill_we_q;
  assign fill_page   = fill_page_q;
  assign fill_offset = fill_offset_q;
  assign fill_data   = fill_data_q;

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Tag, replacement and fill sequencer for the 4-page bus cache on the 65816-style phi2 bus.
- Reconstructs the 24-bit CPU address: bank is taken from d while phi2 is low, and the low 16 bits from a while phi2 is high.
- Looks the page up against four tag registers and reports a hit.
- On a miss, stalls the CPU via rdy, picks an LRU victim, streams 256 bytes from backing memory into that page over a req/ack handshake, then releases rdy.

Parameters:
PAGES, 4, number of cache pages (fixed at 4; page index is 2 bits)
PAGE_BITS, 8, log2 bytes per page; tag = addr[23:PAGE_BITS]
ADDR_W, 24, CPU address width

Ports:
fpga  in  1  system clock; all state is clocked on its rising edge
reset  in  1  asynchronous, active-high reset
phi2  in  1  CPU phase-2 clock, asynchronous to fpga
a  in  16  CPU address bus, valid while phi2 high
d  in  8  CPU data bus; carries the bank byte while phi2 low
invalidate  in  1  single-cycle pulse; clears all valid bits
mem_data  in  8  backing-memory read data, valid with mem_ack
mem_ack  in  1  backing-memory acknowledge
hit  out  1  one-cycle pulse: lookup hit
hit_page  out  2  page index of the last hit or completed fill
rdy  out  1  CPU ready; low while a fill is in progress
mem_req  out  1  backing-memory read request
mem_addr  out  24  backing-memory byte address
fill_we  out  1  one-cycle write strobe into the cache page RAM
fill_page  out  2  victim page being filled
fill_offset  out  8  byte offset within the page
fill_data  out  8  byte to write, valid with fill_we

Behaviour:
- Reset values:
  - Outputs: hit=0, hit_page=0, rdy=1, mem_req=0, mem_addr=0, fill_we=0, fill_page=0, fill_offset=0, fill_data=0.
  - Internal: all valid=0, all tags=0, LRU ages page0..3 = 0,1,2,3, FSM=IDLE.
  - Reset asserted mid-fill aborts the fill immediately. The victim stays invalid.
- Input capture:
  - phi2, a and d each pass through identical 2-flop pipelines (s1, s2); all logic uses the s2 values.
  - A third flop on phi2 (s3) provides edge detection.
- bank_lat loads d_s2 every cycle phi2_s2=0. addr_lat loads a_s2 every cycle phi2_s2=1.
- Lookup event: phi2_s2=0 and phi2_s3=1 (falling edge). Full address A = {bank_lat, addr_lat}.
- FSM states: IDLE, LOOKUP, REQ, WRITE, DONE.
  - IDLE: on a lookup event, register A and go to LOOKUP.
  - LOOKUP (1 cycle): compare A[23:8] with the tags of all valid pages.
    - Hit: next cycle hit=1 for 1 cycle, hit_page=matching index, LRU touch, return to IDLE.
    - Miss: choose the victim, rdy=0 from the next cycle, fill_page=victim, fill_offset=0, go to REQ.
  - REQ: mem_req=1 with mem_addr={A[23:8], fill_offset}. Both are held stable until mem_ack is sampled high.
    - On ack: latch mem_data into fill_data, go to WRITE.
  - WRITE (1 cycle): fill_we=1 and mem_req=0. The requester always sees at least one low cycle between requests.
    - If fill_offset=255, go to DONE. Otherwise increment fill_offset and go to REQ.
  - DONE (1 cycle): tag[victim]=A[23:8], valid[victim]=1, LRU touch victim, hit_page=victim, rdy=1 next cycle, go to IDLE. hit is not pulsed.
- Victim selection:
  - If any page is invalid, use the lowest-index invalid page.
  - Otherwise use the page with age=3. Exactly one such page always exists.
- LRU touch(p): pages with age < age[p] increment by 1, then age[p]=0. Ages remain a permutation of 0..3.
- Lookup events outside IDLE are ignored, not queued.
- mem_ack outside REQ is ignored.
- invalidate:
  - In IDLE or LOOKUP it clears all valid bits on the next edge. A concurrent LOOKUP resolves against the pre-clear valid bits.
  - During REQ/WRITE/DONE it is held pending and applied on IDLE entry, which also clears the just-filled page.
  - LRU ages are unchanged by invalidate.

Test Plan:
- After reset, one bus cycle at A=0x12_3456 -> miss.
  - rdy falls 4 cycles after the phi2 fall.
  - Page 0 receives 256 fill_we pulses, with mem_addr 0x123400..0x1234FF.
  - rdy rises; hit_page=0, valid[0]=1.
- Repeat access to 0x12_34A0 after that fill -> hit=1 one cycle, hit_page=0, rdy stays 1, no mem_req.
- Fill pages with tags 0x1000, 0x2000, 0x3000, 0x4000, touch 0x1000, then miss on 0x5000 -> victim page 1 (0x2000 evicted), fill_page=1.
- mem_ack delayed 0..7 random cycles per byte -> mem_addr stable while mem_req=1, mem_req low exactly 1 cycle after each ack, fill_data matches mem_data sequence.
- invalidate during fill at offset 0x80 -> fill completes all 256 bytes; the next access to the same tag misses and refills page 0.
- reset asserted at offset 0x40 -> mem_req=0 and rdy=1 immediately; next access to the same tag misses and fills page 0 from offset 0.
